// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_pkg
// Brief    : Shared PS/2 definitions: FSM encodings, frame length, default
//            timing constants and the odd-parity helper used by TX and RX.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ps2_state_t;

    localparam int c_frame_bits         = 11;
    localparam int c_data_bits          = 8;
    localparam int c_filt_len           = 4;

    // Defaults assume a 40 MHz pclk.
    localparam int c_inhibit_cycles_def = 4000;
    localparam int c_rts_cycles_def     = 800;
    localparam int c_timeout_cycles_def = 600000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage : ps2_host_tx_pkg
`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_sync
// Brief    : 2-FF synchronisers for ps2_clk/ps2_data, optional clock glitch
//            filter (PS2_TX_GLITCH_FILTER_EN) and clock falling-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_sync
    import ps2_host_tx_pkg::*;
(
    input  logic pclk,
    input  logic rst,
    input  logic i_clk_raw,
    input  logic i_data_raw,
    output logic o_clk_sync,
    output logic o_data_sync,
    output logic o_fall
);

    logic [1:0] r_clk_meta;
    logic [1:0] r_data_meta;
    logic       r_clk_prev;
    logic       w_clk_lvl;

    // Reset to the idle (released-high) level so no false fall follows reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_clk_meta  <= 2'b11;
            r_data_meta <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_meta  <= {r_clk_meta[0], i_clk_raw};
            r_data_meta <= {r_data_meta[0], i_data_raw};
            r_clk_prev  <= w_clk_lvl;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    logic [c_filt_len-1:0] r_hist;
    logic                  r_clk_filt;

    // Filtered level only follows after c_filt_len consecutive equal samples.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hist     <= '1;
            r_clk_filt <= 1'b1;
        end else begin
            r_hist <= {r_hist[c_filt_len-2:0], r_clk_meta[1]};
            if (r_hist == '0) begin
                r_clk_filt <= 1'b0;
            end else if (&r_hist) begin
                r_clk_filt <= 1'b1;
            end
        end
    end

    assign w_clk_lvl = r_clk_filt;
`else
    assign w_clk_lvl = r_clk_meta[1];
`endif

    assign o_clk_sync  = w_clk_lvl;
    assign o_data_sync = r_data_meta[1];
    assign o_fall      = r_clk_prev & ~w_clk_lvl;

endmodule : ps2_line_sync
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : Host-to-device PS/2 command transmitter (inhibit, request-to-send,
//            11-bit frame, ACK check, timeout). Option: PS2_TX_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = c_inhibit_cycles_def,
    parameter int RTS_CYCLES     = c_rts_cycles_def,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles_def
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int c_phase_max = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_cnt_w     = $clog2(c_phase_max + 1);
    localparam int c_tmo_w     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_cnt_w-1:0] c_inhibit_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_rts_last     = c_cnt_w'(RTS_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last     = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         c_idx_parity   = 4'(c_data_bits);
    localparam logic [3:0]         c_idx_stop     = 4'(c_frame_bits - 2);

    ps2_state_t         r_state;
    logic [7:0]         r_data;
    logic               r_parity;
    logic [3:0]         r_bit_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_tmo_w-1:0] r_tmo;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic w_clk_sync;
    logic w_data_sync;
    logic w_fall;

    ps2_line_sync u_line_sync (
        .pclk        (pclk),
        .rst         (rst),
        .i_clk_raw   (ps2_clk_in),
        .i_data_raw  (ps2_data_in),
        .o_clk_sync  (w_clk_sync),
        .o_data_sync (w_data_sync),
        .o_fall      (w_fall)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        r_data    <= tx_data;
                        r_parity  <= odd_parity(tx_data);
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_cnt == c_inhibit_last) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;
                        r_state   <= ST_RTS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RTS: begin
                    if (r_cnt == c_rts_last) begin
                        r_cnt     <= '0;
                        r_clk_oe  <= 1'b0;
                        r_bit_idx <= '0;
                        r_tmo     <= '0;
                        r_state   <= ST_XFER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // r_bit_idx counts device clock falls already seen in this frame.
                ST_XFER: begin
                    if (w_fall) begin
                        r_tmo     <= '0;
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx < c_idx_parity) begin
                            r_data_oe <= ~r_data[r_bit_idx[2:0]];
                        end else if (r_bit_idx == c_idx_parity) begin
                            r_data_oe <= ~r_parity;
                        end else if (r_bit_idx == c_idx_stop) begin
                            r_data_oe <= 1'b0;
                        end else if (w_data_sync) begin
                            r_error   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_state   <= ST_WAIT_IDLE;
                        end
                    end else if (r_tmo == c_tmo_last) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (w_clk_sync && w_data_sync) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_fall) begin
                        r_tmo <= '0;
                    end else if (r_tmo == c_tmo_last) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_error   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;

endmodule : ps2_host_tx
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int c_inh  = 40;
    localparam int c_rts  = 20;
    localparam int c_tmo  = 2000;
    localparam int c_half = 50;

    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;
    localparam int M_RESET  = 3;
    localparam int M_GLITCH = 4;

    typedef struct {
        logic [7:0] data;
        bit         exp_done;
        bit         exp_frame;
        bit         exp_timeout;
    } exp_t;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;

    exp_t       sb_q[$];
    logic [9:0] cap_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         release_cyc = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_inh),
        .RTS_CYCLES     (c_rts),
        .TIMEOUT_CYCLES (c_tmo)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame as the device should see it on the wire after each fall.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    initial begin : monitor
        logic prev_pulse;
        logic prev_clk_oe;
        exp_t e;
        prev_pulse  = 1'b0;
        prev_clk_oe = 1'b0;
        forever begin
            @(negedge pclk);
            if (prev_clk_oe && !ps2_clk_oe) release_cyc = cyc;
            prev_clk_oe = ps2_clk_oe;
            if (prev_pulse) chk("pulse_one_cycle", {30'd0, done, error}, 32'd0);
            prev_pulse = done | error;
            if (done || error) begin
                chk("done_error_exclusive", done & error, 0);
                chk("busy_low_at_pulse", busy, 0);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none", done, error);
                end else begin
                    e = sb_q.pop_front();
                    chk("outcome_done", done, e.exp_done);
                    chk("outcome_error", error, !e.exp_done);
                    if (error) begin
                        chk("err_clk_released", ps2_clk_oe, 0);
                        chk("err_data_released", ps2_data_oe, 0);
                    end
                    if (e.exp_timeout) chk("timeout_latency", cyc - release_cyc, c_tmo);
                    if (e.exp_frame) begin
                        if (cap_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL frame_missing: got no captured frame expected %0h", model_frame(e.data));
                        end else begin
                            chk("frame_bits", cap_q.pop_front(), model_frame(e.data));
                        end
                    end
                end
            end
        end
    end

    task automatic start_tx(input logic [7:0] b, input bit d, input bit fr, input bit tmo, input bit push);
        exp_t e;
        @(negedge pclk);
        chk("busy_before_start", busy, 0);
        tx_data  = b;
        tx_start = 1'b1;
        if (push) begin
            e.data = b; e.exp_done = d; e.exp_frame = fr; e.exp_timeout = tmo;
            sb_q.push_back(e);
        end
        @(negedge pclk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("clk_oe_after_accept", ps2_clk_oe, 1);
    endtask

    // Behavioural device: waits for request-to-send, then clocks the frame.
    task automatic dev_run(input int mode);
        int n;
        logic [9:0] cap;
        cap = '0;
        n = 0;
        while (ps2_clk_oe && n < c_inh + c_rts + 20) begin
            @(posedge pclk);
            n++;
        end
        #1;
        chk("clk_released", ps2_clk_oe, 0);
        chk("start_bit_driven", ps2_data_oe, 1);
        if (mode == M_SILENT) return;
        repeat (20) @(posedge pclk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (c_half) @(posedge pclk);
            if (mode == M_RESET && k == 5) return;
            if (k <= 10) cap[k-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (k == 10) begin
                cap_q.push_back(cap);
                if (mode != M_NACK) dev_data_low = 1'b1;
            end
            if (mode == M_GLITCH && k == 3) begin
                repeat (10) @(posedge pclk);
                dev_clk_low = 1'b1;
                repeat (2) @(posedge pclk);
                dev_clk_low = 1'b0;
                repeat (c_half - 12) @(posedge pclk);
            end else begin
                repeat (c_half) @(posedge pclk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk("wait_idle", busy, 0);
        repeat (5) @(negedge pclk);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no finish expected completion by 800 us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0] b;
        repeat (4) @(negedge pclk);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;
        repeat (4) @(negedge pclk);

        start_tx(8'hF4, 1, 1, 0, 1);
        dev_run(M_ACK);
        wait_idle(2000);

        start_tx(8'hFF, 1, 1, 0, 1);
        dev_run(M_ACK);
        wait_idle(2000);

        start_tx(8'($urandom), 0, 1, 0, 1);
        dev_run(M_NACK);
        wait_idle(2000);

        start_tx(8'($urandom), 0, 0, 1, 1);
        dev_run(M_SILENT);
        wait_idle(c_tmo + 100);

        start_tx(8'($urandom), 0, 0, 0, 0);
        dev_run(M_RESET);
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_data_oe", ps2_data_oe, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge pclk);

        b = 8'($urandom_range(1, 255));
        start_tx(b, 1, 1, 0, 1);
        repeat (5) @(negedge pclk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge pclk);
        tx_start = 1'b0;
        dev_run(M_ACK);
        wait_idle(2000);

        for (int i = 0; i < 6; i++) begin
            start_tx(8'($urandom), 1, 1, 0, 1);
            dev_run(M_ACK);
            wait_idle(2000);
        end

`ifdef PS2_TX_GLITCH_FILTER_EN
        start_tx(8'($urandom), 1, 1, 0, 1);
        dev_run(M_GLITCH);
        wait_idle(2000);
`endif

        repeat (10) @(negedge pclk);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("captures_drained", cap_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ps2_host_tx
`default_nettype wire
